pgm_boot_loader: RTL and testbench
==================================

// Module: pgm_boot_loader
// PURPOSE
//  Boot-time sequencer for the CPU's 256x8 program memory. Holds the CPU in reset while it receives a framed
//  byte stream on a valid/ready port. Writes the payload into program memory from address 0, checks the
//  checksum, then releases the CPU. Sits between the host/debug byte source, the program memory write port
//  and the CPU reset input.
// PARAMETERS
//  ADDR_W    8     program memory address width; frame length 0 means 2**ADDR_W bytes
//  DATA_W    8     byte width of stream, memory and checksum
//  SYNC_BYTE 8'hA5 frame start marker
//  TIMEOUT   1024  idle cycles allowed mid-frame before error; 0 disables the timeout
// PORTS
//  clk        in  1      system clock, all state on posedge
//  reset_n    in  1      asynchronous, active-low reset
//  in_valid   in  1      byte source has in_data
//  in_data    in  DATA_W stream byte
//  in_ready   out 1      loader accepts byte this cycle (accept = in_valid & in_ready at posedge)
//  reload     in  1      one-cycle request to stop the CPU and take a new frame
//  pgm_we     out 1      program memory write strobe, one cycle per payload byte
//  pgm_addr   out ADDR_W program memory write address
//  pgm_wdata  out DATA_W program memory write data
//  cpu_reset  out 1      active-high reset to CPU
//  done       out 1      image loaded and verified; CPU running
//  err        out 1      last frame failed (bad checksum or timeout)
// BEHAVIOUR
//  Reset (async, reset_n=0): state=SYNC; cpu_reset=1 immediately; pgm_we=0, pgm_addr=0, pgm_wdata=0,
//   done=0, err=0; counters and checksum cleared. All outputs are registered except in_ready, which is
//   decoded from state.
//  Frame format: SYNC_BYTE, L, L payload bytes, C. L=0 means 256 bytes. The frame is valid when
//   (sum of payload + C) mod 256 == 0.
//  States:
//   SYNC - in_ready=1. Bytes other than SYNC_BYTE are discarded. SYNC_BYTE -> LEN.
//   LEN  - in_ready=1. Accept L; remaining=L (0 maps to 256); addr=0, sum=0 -> DATA.
//   DATA - in_ready=1. Each accepted byte b: next cycle pgm_we=1, pgm_addr=addr, pgm_wdata=b;
//          then addr+=1 (wraps mod 256), sum+=b mod 256, remaining-=1. Last byte -> CHK.
//   CHK  - in_ready=1. Accept C. If sum+C==0: -> RUN, and the next cycle cpu_reset=0, done=1, err=0.
//          Otherwise: -> ERR, err=1, cpu_reset stays 1.
//   RUN  - in_ready=0. Stream is ignored. reload=1 -> SYNC; next cycle cpu_reset=1, done=0.
//   ERR  - in_ready=1, err=1, cpu_reset=1. An accepted SYNC_BYTE -> LEN and clears err. Other bytes are discarded.
//  Latency: write strobe 1 cycle after byte acceptance. CPU release 1 cycle after checksum acceptance.
//  Timeout: in LEN/DATA/CHK, an idle counter increments on every cycle with no accepted byte and clears on
//   acceptance. When it reaches TIMEOUT: -> ERR, err=1. Payload already written is left in memory.
//  Edge cases:
//   - reload outside RUN is ignored.
//   - reload with in_valid in RUN: reload wins, no byte is consumed.
//   - pgm_we is never asserted outside DATA acceptances. Exactly L writes per frame; no write at address 256.
//   - A frame of L=256 wraps pgm_addr 0xFF->0x00 only after the final write.
//   - A SYNC_BYTE value inside LEN/DATA/CHK is treated as data, not as a resync.
//   - reset_n asserted mid-frame aborts the frame; memory contents are undefined for the bench.
// STRUCTURE
//  Shared package pgm_boot_pkg: state encoding constants (SYNC, LEN, DATA, CHK, RUN, ERR) and the
//   default SYNC_BYTE.
//  One sub-module: pgm_idle_timer (clog2(TIMEOUT+1)-bit counter with clear, enable and expire output,
//   async active-low reset). Everything else stays in one always block plus an in_ready decode.
// TESTING
//  1 reset_n low 3 cycles, send A5 03 80 FF D0 B1 -> writes 0:80 1:FF 2:D0; cpu_reset=0 and done=1
//    one cycle after B1 is accepted.
//  2 A5 03 80 FF D0 00 -> same 3 writes, err=1, done=0, cpu_reset stays 1; then a good frame recovers
//    (err=0, done=1).
//  3 00 13 A5 01 42 BE -> exactly one write (0:42); leading 00 13 are dropped; done=1.
//  4 A5 00, 256 bytes k=0..255 (value k), C=0x80 -> 256 writes, addr 0..FF in order, none at wrap, done=1.
//  5 TIMEOUT=8: A5 02 11, then in_valid=0 for 8 cycles -> err=1, only 0:11 written, cpu_reset=1.
//  6 In RUN, pulse reload with in_valid=1 -> in_ready stays 0, cpu_reset=1 and done=0 next cycle.
//    Then reset_n low mid-DATA -> cpu_reset=1 and pgm_we=0 without waiting for a clock edge.

Source files
------------

// File: rtl/pgm_boot_pkg.sv
// Shared definitions for the program-memory boot loader: FSM state
// encoding and the default frame start marker.
package pgm_boot_pkg;

    typedef enum logic [2:0] {
        S_SYNC = 3'd0,
        S_LEN  = 3'd1,
        S_DATA = 3'd2,
        S_CHK  = 3'd3,
        S_RUN  = 3'd4,
        S_ERR  = 3'd5
    } boot_state_t;

    localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

    // True for the states that are in the middle of receiving a frame and
    // therefore subject to the idle timeout.
    function automatic logic in_frame(input boot_state_t st);
        return (st == S_LEN) || (st == S_DATA) || (st == S_CHK);
    endfunction

endpackage

// File: rtl/pgm_idle_timer.sv
// Idle-cycle counter for the boot loader. Counts enabled cycles, clears on
// request, and flags expiry on the cycle whose count would reach TIMEOUT.
// TIMEOUT of 0 disables expiry entirely.
module pgm_idle_timer #(
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expire
);

    localparam int unsigned CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] LAST_IDLE = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] r_count;
    logic             w_enabled_timeout;

    assign w_enabled_timeout = (TIMEOUT != 0);

    // Expire as the count steps onto TIMEOUT, so the owner leaves the frame
    // on exactly the TIMEOUT-th idle cycle.
    assign o_expire = w_enabled_timeout && i_enable && !i_clear && (r_count == LAST_IDLE);

    // Idle counter: clear has priority over counting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable) begin
            r_count <= r_count + 1'b1;
        end
    end

endmodule

// File: rtl/pgm_boot_loader.sv
// Boot-time sequencer for the CPU program memory. Keeps the CPU in reset,
// receives a framed byte stream (SYNC, L, payload, checksum), writes the
// payload from address 0 and releases the CPU when the checksum matches.
module pgm_boot_loader
    import pgm_boot_pkg::*;
#(
    parameter int unsigned        ADDR_W    = 8,
    parameter int unsigned        DATA_W    = 8,
    parameter logic [DATA_W-1:0]  SYNC_BYTE = DATA_W'(DEFAULT_SYNC_BYTE),
    parameter int unsigned        TIMEOUT   = 1024
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    input  logic              reload,
    output logic              pgm_we,
    output logic [ADDR_W-1:0] pgm_addr,
    output logic [DATA_W-1:0] pgm_wdata,
    output logic              cpu_reset,
    output logic              done,
    output logic              err
);

    localparam logic [ADDR_W:0] FULL_LEN = (ADDR_W+1)'(1) << ADDR_W;

    boot_state_t       r_state,     r_state_next;
    logic [ADDR_W:0]   r_remaining, r_remaining_next;
    logic [ADDR_W-1:0] r_wr_addr,   r_wr_addr_next;
    logic [DATA_W-1:0] r_sum,       r_sum_next;
    logic              r_pgm_we,    r_pgm_we_next;
    logic [ADDR_W-1:0] r_pgm_addr,  r_pgm_addr_next;
    logic [DATA_W-1:0] r_pgm_wdata, r_pgm_wdata_next;
    logic              r_cpu_reset, r_cpu_reset_next;
    logic              r_done,      r_done_next;
    logic              r_err,       r_err_next;

    logic              w_accept;
    logic              w_in_frame;
    logic              w_expire;
    logic [ADDR_W:0]   w_len;
    logic [DATA_W-1:0] w_sum_plus_byte;

    // The stream is refused only while the CPU is running.
    assign in_ready        = (r_state != S_RUN);
    assign w_accept        = in_valid && in_ready;
    assign w_in_frame      = in_frame(r_state);
    assign w_sum_plus_byte = r_sum + in_data;

    // A length byte of zero stands for a full memory image.
    assign w_len = ((ADDR_W+1)'(in_data) == '0) ? FULL_LEN : (ADDR_W+1)'(in_data);

    pgm_idle_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_idle_timer (
        .clk      (clk),
        .rst_n    (reset_n),
        .i_clear  (w_accept || !w_in_frame),
        .i_enable (w_in_frame && !w_accept),
        .o_expire (w_expire)
    );

    // Next-state and registered-output decode for the frame sequencer.
    always_comb begin
        r_state_next     = r_state;
        r_remaining_next = r_remaining;
        r_wr_addr_next   = r_wr_addr;
        r_sum_next       = r_sum;
        r_pgm_we_next    = 1'b0;
        r_pgm_addr_next  = r_pgm_addr;
        r_pgm_wdata_next = r_pgm_wdata;
        r_cpu_reset_next = r_cpu_reset;
        r_done_next      = r_done;
        r_err_next       = r_err;

        unique case (r_state)
            S_SYNC: begin
                if (w_accept && in_data == SYNC_BYTE) begin
                    r_state_next = S_LEN;
                end
            end
            S_LEN: begin
                if (w_accept) begin
                    r_remaining_next = w_len;
                    r_wr_addr_next   = '0;
                    r_sum_next       = '0;
                    r_state_next     = S_DATA;
                end
            end
            S_DATA: begin
                if (w_accept) begin
                    r_pgm_we_next    = 1'b1;
                    r_pgm_addr_next  = r_wr_addr;
                    r_pgm_wdata_next = in_data;
                    r_wr_addr_next   = r_wr_addr + 1'b1;
                    r_sum_next       = w_sum_plus_byte;
                    r_remaining_next = r_remaining - 1'b1;
                    if (r_remaining == (ADDR_W+1)'(1)) begin
                        r_state_next = S_CHK;
                    end
                end
            end
            S_CHK: begin
                if (w_accept) begin
                    if (w_sum_plus_byte == '0) begin
                        r_state_next     = S_RUN;
                        r_cpu_reset_next = 1'b0;
                        r_done_next      = 1'b1;
                        r_err_next       = 1'b0;
                    end else begin
                        r_state_next     = S_ERR;
                        r_err_next       = 1'b1;
                        r_cpu_reset_next = 1'b1;
                        r_done_next      = 1'b0;
                    end
                end
            end
            S_RUN: begin
                // Incoming bytes are not accepted here, so reload cannot race one.
                if (reload) begin
                    r_state_next     = S_SYNC;
                    r_cpu_reset_next = 1'b1;
                    r_done_next      = 1'b0;
                end
            end
            S_ERR: begin
                if (w_accept && in_data == SYNC_BYTE) begin
                    r_state_next = S_LEN;
                    r_err_next   = 1'b0;
                end
            end
            default: begin
                r_state_next     = S_SYNC;
                r_cpu_reset_next = 1'b1;
                r_done_next      = 1'b0;
            end
        endcase

        // An abandoned frame keeps whatever payload already reached memory.
        if (w_expire) begin
            r_state_next     = S_ERR;
            r_err_next       = 1'b1;
            r_cpu_reset_next = 1'b1;
            r_done_next      = 1'b0;
        end
    end

    // State and output registers; reset parks the CPU immediately.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_SYNC;
            r_remaining <= '0;
            r_wr_addr   <= '0;
            r_sum       <= '0;
            r_pgm_we    <= 1'b0;
            r_pgm_addr  <= '0;
            r_pgm_wdata <= '0;
            r_cpu_reset <= 1'b1;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_state     <= r_state_next;
            r_remaining <= r_remaining_next;
            r_wr_addr   <= r_wr_addr_next;
            r_sum       <= r_sum_next;
            r_pgm_we    <= r_pgm_we_next;
            r_pgm_addr  <= r_pgm_addr_next;
            r_pgm_wdata <= r_pgm_wdata_next;
            r_cpu_reset <= r_cpu_reset_next;
            r_done      <= r_done_next;
            r_err       <= r_err_next;
        end
    end

    assign pgm_we    = r_pgm_we;
    assign pgm_addr  = r_pgm_addr;
    assign pgm_wdata = r_pgm_wdata;
    assign cpu_reset = r_cpu_reset;
    assign done      = r_done;
    assign err       = r_err;

endmodule

// File: tb/tb_pgm_boot_loader.sv
// Self-checking bench for pgm_boot_loader. Expected memory writes are queued
// as payload bytes are driven and matched by a monitor as pgm_we pulses.
module tb_pgm_boot_loader;

    logic       clk;
    logic       reset_n;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       reload;
    logic       pgm_we;
    logic [7:0] pgm_addr;
    logic [7:0] pgm_wdata;
    logic       cpu_reset;
    logic       done;
    logic       err;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] exp_q[$];

    pgm_boot_loader #(
        .ADDR_W    (8),
        .DATA_W    (8),
        .SYNC_BYTE (8'hA5),
        .TIMEOUT   (8)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .reload    (reload),
        .pgm_we    (pgm_we),
        .pgm_addr  (pgm_addr),
        .pgm_wdata (pgm_wdata),
        .cpu_reset (cpu_reset),
        .done      (done),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Write monitor: every strobe must match the oldest queued expectation.
    always @(negedge clk) begin
        if (reset_n && pgm_we) begin
            logic [15:0] exp_w;
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_write: got %02h:%02h, required no write", pgm_addr, pgm_wdata);
            end else begin
                exp_w = exp_q.pop_front();
                if ({pgm_addr, pgm_wdata} !== exp_w) begin
                    n_fail++;
                    $display("FAIL write: got %02h:%02h, required %02h:%02h",
                             pgm_addr, pgm_wdata, exp_w[15:8], exp_w[7:0]);
                end else begin
                    $display("write %02h:%02h ok", pgm_addr, pgm_wdata);
                end
            end
        end
    end

    // Present a byte and hold it until the loader accepts it; returns on the
    // falling edge after the accepting rising edge.
    task automatic send_byte(input logic [7:0] b);
        int waited;
        waited   = 0;
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL ready_timeout: byte %02h, in_ready got %b required 1", b, in_ready);
        end
        @(negedge clk);
    endtask

    // Payload byte: queue the write it should cause, then send it.
    task automatic send_data(input logic [7:0] addr, input logic [7:0] b);
        exp_q.push_back({addr, b});
        send_byte(b);
    endtask

    task automatic go_idle();
        in_valid = 1'b0;
        in_data  = 8'h00;
    endtask

    // Let pending write strobes drain, then require the queue to be empty.
    task automatic check_drained(input string name);
        @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s_writes: %0d writes missing, required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic check_status(input string name, input logic e_done,
                                input logic e_cpu_reset, input logic e_err);
        n_checks++;
        if ({done, cpu_reset, err} !== {e_done, e_cpu_reset, e_err}) begin
            n_fail++;
            $display("FAIL %s: done/cpu_reset/err got %b%b%b required %b%b%b",
                     name, done, cpu_reset, err, e_done, e_cpu_reset, e_err);
        end else begin
            $display("%s: done=%b cpu_reset=%b err=%b", name, done, cpu_reset, err);
        end
    endtask

    task automatic do_reload();
        @(negedge clk);
        reload = 1'b1;
        @(negedge clk);
        reload = 1'b0;
        check_status("reload", 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_reset();
        reset_n  = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        reload   = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({pgm_we, pgm_addr, pgm_wdata, in_ready} !== {1'b0, 8'h00, 8'h00, 1'b1}) begin
            n_fail++;
            $display("FAIL reset_outputs: we/addr/wdata/ready got %b %02h %02h %b required 0 00 00 1",
                     pgm_we, pgm_addr, pgm_wdata, in_ready);
        end
        check_status("reset", 1'b0, 1'b1, 1'b0);
        reset_n = 1'b1;
        @(negedge clk);
        check_status("after_reset", 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_good_frame();
        send_byte(8'hA5);
        send_byte(8'h03);
        send_data(8'h00, 8'h80);
        send_data(8'h01, 8'hFF);
        send_data(8'h02, 8'hD0);
        check_status("before_chk", 1'b0, 1'b1, 1'b0);
        send_byte(8'hB1);
        go_idle();
        check_status("good_frame", 1'b1, 1'b0, 1'b0);
        check_drained("good_frame");
    endtask

    task automatic test_bad_checksum();
        do_reload();
        send_byte(8'hA5);
        send_byte(8'h03);
        send_data(8'h00, 8'h80);
        send_data(8'h01, 8'hFF);
        send_data(8'h02, 8'hD0);
        send_byte(8'h00);
        go_idle();
        check_status("bad_checksum", 1'b0, 1'b1, 1'b1);
        check_drained("bad_checksum");
        send_byte(8'hA5);
        send_byte(8'h01);
        send_data(8'h00, 8'h07);
        send_byte(8'hF9);
        go_idle();
        check_status("recover", 1'b1, 1'b0, 1'b0);
        check_drained("recover");
    endtask

    task automatic test_resync();
        do_reload();
        send_byte(8'h00);
        send_byte(8'h13);
        send_byte(8'hA5);
        send_byte(8'h01);
        send_data(8'h00, 8'h42);
        send_byte(8'hBE);
        go_idle();
        check_status("resync", 1'b1, 1'b0, 1'b0);
        check_drained("resync");
    endtask

    task automatic test_full_image();
        do_reload();
        send_byte(8'hA5);
        send_byte(8'h00);
        for (int k = 0; k < 256; k++) begin
            send_data(8'(k), 8'(k));
        end
        send_byte(8'h80);
        go_idle();
        check_status("full_image", 1'b1, 1'b0, 1'b0);
        check_drained("full_image");
    endtask

    task automatic test_timeout();
        do_reload();
        send_byte(8'hA5);
        send_byte(8'h02);
        send_data(8'h00, 8'h11);
        go_idle();
        repeat (7) @(negedge clk);
        check_status("timeout_7_idle", 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        check_status("timeout_8_idle", 1'b0, 1'b1, 1'b1);
        check_drained("timeout");
    endtask

    task automatic test_reload_and_async_reset();
        // Leave ERR with a good one-byte frame.
        send_byte(8'hA5);
        send_byte(8'h01);
        send_data(8'h00, 8'h01);
        send_byte(8'hFF);
        go_idle();
        check_status("err_recover", 1'b1, 1'b0, 1'b0);
        check_drained("err_recover");
        // Reload while a byte is offered: the byte must not be taken.
        reload   = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'hA5;
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL run_ready: in_ready got %b required 0", in_ready);
        end
        @(negedge clk);
        reload = 1'b0;
        go_idle();
        check_status("reload_with_valid", 1'b0, 1'b1, 1'b0);
        // A new frame still needs its own SYNC byte.
        send_byte(8'h01);
        send_byte(8'hA5);
        send_byte(8'h03);
        send_data(8'h00, 8'h11);
        go_idle();
        #1;
        n_checks++;
        if (pgm_we !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_data_we: pgm_we got %b required 1", pgm_we);
        end
        reset_n = 1'b0;
        #1;
        n_checks++;
        if ({pgm_we, cpu_reset, done} !== 3'b010) begin
            n_fail++;
            $display("FAIL async_reset: we/cpu_reset/done got %b%b%b required 010",
                     pgm_we, cpu_reset, done);
        end else begin
            $display("async_reset: pgm_we=%b cpu_reset=%b", pgm_we, cpu_reset);
        end
        @(negedge clk);
        reset_n = 1'b1;
        exp_q.delete();
        send_byte(8'hA5);
        send_byte(8'h01);
        send_data(8'h00, 8'h5A);
        send_byte(8'hA6);
        go_idle();
        check_status("after_async_reset", 1'b1, 1'b0, 1'b0);
        check_drained("after_async_reset");
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_bad_checksum();
        test_resync();
        test_full_image();
        test_timeout();
        test_reload_and_async_reset();
        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
